// File: rtl/udp_tx_framer.sv
// UDP tx framer: 8-byte header then payload on a DATA_BYTES-wide stream; payload latency 1, done/chksum 1 cycle after m_last.
// Backpressure: payload accepted only when the output register is empty or draining; output held while m_valid & !m_ready.
module udp_tx_framer #(
  parameter int DATA_BYTES = 4,
  parameter bit CHKSUM_EN  = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hdr_valid,
  output logic                      hdr_ready,
  input  logic [31:0]               src_ip,
  input  logic [31:0]               dest_ip,
  input  logic [15:0]               src_port,
  input  logic [15:0]               dest_port,
  input  logic [15:0]               pay_len,
  input  logic                      no_chksum,
  input  logic [8*DATA_BYTES-1:0]   s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [8*DATA_BYTES-1:0]   m_data,
  output logic [DATA_BYTES-1:0]     m_keep,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic [15:0]               udp_len,
  output logic [15:0]               chksum,
  output logic                      done,
  output logic                      err
);
  localparam int W = 8 * DATA_BYTES;
  localparam logic [15:0] DB16    = 16'(DATA_BYTES);
  localparam logic [15:0] MAX_PAY = 16'd65527;

  typedef enum logic [1:0] {IDLE, HDR, DATA, FIN} state_t;

  state_t                state_q;
  logic                  hdr_ready_q, m_valid_q, m_last_q, done_q, err_q;
  logic                  err_pend_q, no_chksum_q, hdr_idx_q;
  logic [W-1:0]          m_data_q;
  logic [DATA_BYTES-1:0] m_keep_q;
  logic [15:0]           udp_len_q, chksum_q, bytes_left_q, src_port_q, dest_port_q;
  logic [31:0]           acc_q;

  logic                  out_free, fin_go, beat_final, hdr_last;
  logic [63:0]           hdr64;
  logic [W-1:0]          hdr_beat, pay_beat;
  logic [DATA_BYTES-1:0] pay_keep;
  logic [15:0]           hdr_ulen, fold2, chk_d;
  logic [31:0]           hdr_sum, beat_sum, acc_d;
  logic [32:0]           acc_wide;
  logic [16:0]           fold1;

  assign out_free   = !m_valid_q || m_ready;
  assign fin_go     = (state_q == HDR || state_q == DATA) && m_valid_q && m_last_q && m_ready;
  assign s_ready    = (state_q == DATA) && !m_last_q && out_free;
  assign beat_final = bytes_left_q <= DB16;
  assign hdr_last   = (DATA_BYTES == 8) || hdr_idx_q;

  always_comb begin
    hdr_ulen = pay_len + 16'd8;
    hdr_sum  = {16'h0, src_ip[31:16]} + {16'h0, src_ip[15:0]} + {16'h0, dest_ip[31:16]}
             + {16'h0, dest_ip[15:0]} + 32'h0000_0011 + {16'h0, hdr_ulen}
             + {16'h0, src_port} + {16'h0, dest_port} + {16'h0, hdr_ulen};

    hdr64 = {src_port_q, dest_port_q, udp_len_q, 16'h0000};
    if (hdr_last) hdr_beat = hdr64[W-1:0];
    else          hdr_beat = hdr64[63:64-W];

    // Bytes past the datagram end are zeroed so the checksum sees the pad bytes as 0.
    pay_beat = s_data;
    pay_keep = '1;
    if (beat_final) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (16'(i) >= bytes_left_q) begin
          pay_beat[W-1-8*i -: 8]   = 8'h00;
          pay_keep[DATA_BYTES-1-i] = 1'b0;
        end
      end
    end

    beat_sum = '0;
    for (int j = 0; j < DATA_BYTES / 2; j++) beat_sum = beat_sum + {16'h0, pay_beat[W-1-16*j -: 16]};
    acc_wide = {1'b0, acc_q} + {1'b0, beat_sum};
    acc_d    = acc_wide[31:0] + {31'h0, acc_wide[32]};

    fold1 = {1'b0, acc_q[31:16]} + {1'b0, acc_q[15:0]};
    fold2 = fold1[15:0] + {15'h0, fold1[16]};
    chk_d = ~fold2;
    if (chk_d == 16'h0000) chk_d = 16'hFFFF;
    if (!CHKSUM_EN || no_chksum_q) chk_d = 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hdr_ready_q  <= 1'b1;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_pend_q   <= 1'b0;
      no_chksum_q  <= 1'b0;
      hdr_idx_q    <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      udp_len_q    <= '0;
      chksum_q     <= '0;
      bytes_left_q <= '0;
      src_port_q   <= '0;
      dest_port_q  <= '0;
      acc_q        <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (m_valid_q && m_ready) m_valid_q <= 1'b0;
      if (fin_go) begin
        state_q  <= FIN;
        done_q   <= 1'b1;
        err_q    <= err_pend_q;
        chksum_q <= chk_d;
      end else begin
        case (state_q)
          IDLE: if (hdr_valid && hdr_ready_q) begin
            if (pay_len > MAX_PAY) begin
              err_q <= 1'b1;
            end else begin
              state_q      <= HDR;
              hdr_ready_q  <= 1'b0;
              hdr_idx_q    <= 1'b0;
              err_pend_q   <= 1'b0;
              no_chksum_q  <= no_chksum;
              src_port_q   <= src_port;
              dest_port_q  <= dest_port;
              udp_len_q    <= hdr_ulen;
              bytes_left_q <= pay_len;
              acc_q        <= CHKSUM_EN ? hdr_sum : 32'h0;
            end
          end
          HDR: if (!m_last_q && out_free) begin
            m_data_q  <= hdr_beat;
            m_keep_q  <= '1;
            m_valid_q <= 1'b1;
            hdr_idx_q <= 1'b1;
            if (hdr_last) begin
              if (bytes_left_q == 16'd0) m_last_q <= 1'b1;
              else                       state_q  <= DATA;
            end
          end
          DATA: if (s_valid && s_ready) begin
            m_data_q     <= pay_beat;
            m_keep_q     <= pay_keep;
            m_valid_q    <= 1'b1;
            m_last_q     <= beat_final || s_last;
            err_pend_q   <= beat_final != s_last;
            bytes_left_q <= bytes_left_q - DB16;
            if (CHKSUM_EN) acc_q <= acc_d;
          end
          FIN: begin
            state_q     <= IDLE;
            hdr_ready_q <= 1'b1;
            m_last_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hdr_ready = hdr_ready_q;
  assign m_data    = m_data_q;
  assign m_keep    = m_keep_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign udp_len   = udp_len_q;
  assign chksum    = chksum_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_udp_tx_framer.sv
// Bench for udp_tx_framer: directed and random datagrams against a byte-stream reference model.
module tb_udp_tx_framer;
  localparam int DB = 4;
  localparam int W  = 8 * DB;

  logic          clk = 1'b0;
  logic          reset;
  logic          hdr_valid, hdr_ready;
  logic [31:0]   src_ip, dest_ip;
  logic [15:0]   src_port, dest_port, pay_len;
  logic          no_chksum;
  logic [W-1:0]  s_data;
  logic          s_valid, s_last, s_ready;
  logic [W-1:0]  m_data;
  logic [DB-1:0] m_keep;
  logic          m_valid, m_last, m_ready;
  logic [15:0]   udp_len, chksum;
  logic          done, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  udp_tx_framer #(.DATA_BYTES(DB), .CHKSUM_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .src_ip(src_ip), .dest_ip(dest_ip), .src_port(src_port), .dest_port(dest_port),
    .pay_len(pay_len), .no_chksum(no_chksum), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .m_data(m_data), .m_keep(m_keep),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .udp_len(udp_len),
    .chksum(chksum), .done(done), .err(err)
  );

  logic [7:0]    pat [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hAB, 8'hCD, 8'h12, 8'h34};
  logic [7:0]    src_bytes[$];
  logic [W-1:0]  exp_dat[$];
  logic [DB-1:0] exp_keep[$];
  logic          exp_lst[$];
  logic [15:0]   exp_chk, exp_ulen, last_ulen;
  logic          exp_err;
  int            exp_cons;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: wire image = 8 header bytes + consumed payload bytes, cut into DB-byte beats.
  task automatic build_model(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                             input logic [15:0] dp, input logic [15:0] plen, input logic nock, input int k);
    logic [7:0]      wb[$];
    int              nb, nvalid, nbeats, v;
    longint unsigned s;
    logic [W-1:0]    d;
    logic [DB-1:0]   kp;
    logic [15:0]     ulen;
    ulen     = plen + 16'd8;
    nb       = (int'(plen) + DB - 1) / DB;
    exp_cons = (k < nb) ? k : nb;
    exp_err  = (k != nb);
    nvalid   = (k < nb) ? k * DB : int'(plen);
    wb = {sp[15:8], sp[7:0], dp[15:8], dp[7:0], ulen[15:8], ulen[7:0], 8'h00, 8'h00};
    for (int i = 0; i < exp_cons * DB; i++) wb.push_back(i < nvalid ? src_bytes[i] : 8'h00);
    nbeats = wb.size() / DB;
    exp_dat.delete(); exp_keep.delete(); exp_lst.delete();
    for (int b = 0; b < nbeats; b++) begin
      for (int j = 0; j < DB; j++) d[W-1-8*j -: 8] = wb[b*DB+j];
      v  = (b == nbeats - 1) ? (8 + nvalid) - b * DB : DB;
      kp = '0;
      for (int j = 0; j < DB; j++) if (j < v) kp[DB-1-j] = 1'b1;
      exp_dat.push_back(d);
      exp_keep.push_back(kp);
      exp_lst.push_back(b == nbeats - 1);
    end
    s = 64'(sip[31:16]) + 64'(sip[15:0]) + 64'(dip[31:16]) + 64'(dip[15:0]) + 64'd17
      + 64'(ulen) + 64'(ulen) + 64'(sp) + 64'(dp);
    for (int i = 0; i < nvalid; i += 2)
      s = s + 64'({src_bytes[i], (i + 1 < nvalid) ? src_bytes[i+1] : 8'h00});
    while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
    exp_chk = ~s[15:0];
    if (exp_chk == 16'h0000) exp_chk = 16'hFFFF;
    if (nock) exp_chk = 16'h0000;
    exp_ulen = ulen;
  endtask

  // k = 1-based source beat carrying s_last (0 = no payload); rmode 0 ready, 1 toggle, 2 random.
  task automatic run_frame(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                           input logic [15:0] dp, input logic [15:0] plen, input logic nock, input int k,
                           input int rmode, input int rst_at, input bit fixed);
    int   si, nx, last_x;
    logic acc, got_done;
    src_bytes.delete();
    for (int i = 0; i < k * DB; i++) src_bytes.push_back(fixed ? pat[i % 8] : 8'($urandom));
    build_model(sip, dip, sp, dp, plen, nock, k);

    hdr_valid = 1'b1; src_ip = sip; dest_ip = dip; src_port = sp; dest_port = dp;
    pay_len = plen; no_chksum = nock;
    acc = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      acc = hdr_ready;
      @(posedge clk); #1;
    end
    hdr_valid = 1'b0;
    check("hdr_accept", 64'(acc), 64'd1);

    si = 0; nx = 0; last_x = -10; got_done = 1'b0;
    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      if (rst_at > 0 && cyc == rst_at) begin
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_hdr_ready", 64'(hdr_ready), 64'd1);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_keep", 64'(m_keep), 64'd0);
        check("rst_udp_len", 64'(udp_len), 64'd0);
        check("rst_chksum", 64'(chksum), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        last_ulen = 16'h0000;
        @(posedge clk); #1;
        return;
      end
      m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      s_valid = (si < k);
      s_last  = 1'b0;
      s_data  = '0;
      if (si < k) begin
        for (int b = 0; b < DB; b++) s_data[W-1-8*b -: 8] = src_bytes[si*DB+b];
        s_last = (si == k - 1);
      end
      @(negedge clk);
      if (m_valid) begin
        if (nx < exp_dat.size()) begin
          check("beat_data", 64'(m_data), 64'(exp_dat[nx]));
          check("beat_keep", 64'(m_keep), 64'(exp_keep[nx]));
          check("beat_last", 64'(m_last), 64'(exp_lst[nx]));
        end else begin
          check("extra_beat", 64'(nx), 64'(exp_dat.size() - 1));
        end
        if (m_ready) begin nx++; last_x = cyc; end
      end
      if (done) begin
        got_done = 1'b1;
        check("done_latency", 64'(cyc - last_x), 64'd1);
        check("chksum", 64'(chksum), 64'(exp_chk));
        check("err_with_done", 64'(err), 64'(exp_err));
        check("udp_len", 64'(udp_len), 64'(exp_ulen));
        check("hdr_ready_fin", 64'(hdr_ready), 64'd0);
      end else begin
        check("err_stray", 64'(err), 64'd0);
      end
      if (s_valid && s_ready) si++;
      @(posedge clk); #1;
    end
    check("done_seen", 64'(got_done), 64'd1);
    check("beat_count", 64'(nx), 64'(exp_dat.size()));
    check("consumed", 64'(si), 64'(exp_cons));
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("hdr_ready_idle", 64'(hdr_ready), 64'd1);
    last_ulen = exp_ulen;
    @(posedge clk); #1;
  endtask

  task automatic reject_hdr(input logic [15:0] plen);
    hdr_valid = 1'b1; pay_len = plen; no_chksum = 1'b0;
    @(negedge clk);
    check("rej_ready_before", 64'(hdr_ready), 64'd1);
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    @(negedge clk);
    check("rej_err", 64'(err), 64'd1);
    check("rej_hdr_ready", 64'(hdr_ready), 64'd1);
    check("rej_m_valid", 64'(m_valid), 64'd0);
    check("rej_udp_len", 64'(udp_len), 64'(last_ulen));
    @(posedge clk); #1;
    @(negedge clk);
    check("rej_err_pulse", 64'(err), 64'd0);
    check("rej_no_output", 64'(m_valid), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int plen, nb, k, r;
    reset = 1'b1; hdr_valid = 1'b0; src_ip = '0; dest_ip = '0; src_port = '0; dest_port = '0;
    pay_len = '0; no_chksum = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    last_ulen = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hdr_ready", 64'(hdr_ready), 64'd1);
    check("reset_s_ready", 64'(s_ready), 64'd0);
    check("reset_m_valid", 64'(m_valid), 64'd0);
    check("reset_m_last", 64'(m_last), 64'd0);
    check("reset_m_data", 64'(m_data), 64'd0);
    check("reset_m_keep", 64'(m_keep), 64'd0);
    check("reset_udp_len", 64'(udp_len), 64'd0);
    check("reset_chksum", 64'(chksum), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_frame(32'hC0A80001, 32'hC0A800C7, 16'h1234, 16'h5678, 16'd4, 1'b0, 1, 0, 0, 1'b1);
    run_frame(32'hC0A80001, 32'hC0A800C7, 16'h1234, 16'h5678, 16'd5, 1'b0, 2, 0, 0, 1'b1);
    run_frame(32'hC0A80001, 32'hC0A800C7, 16'h1234, 16'h5678, 16'd4, 1'b0, 1, 1, 0, 1'b1);
    run_frame(32'h0A000001, 32'h0A000002, 16'd1000, 16'd2000, 16'd8, 1'b0, 1, 0, 0, 1'b0);
    reject_hdr(16'd65530);
    reject_hdr(16'd65528);
    run_frame(32'h0A000001, 32'h0A000002, 16'd53, 16'd53, 16'd12, 1'b1, 3, 1, 0, 1'b0);
    run_frame(32'h0A000001, 32'h0A000002, 16'd7, 16'd9, 16'd0, 1'b0, 0, 1, 0, 1'b0);
    run_frame(32'h0A000003, 32'h0A000004, 16'd7, 16'd9, 16'd6, 1'b0, 3, 0, 0, 1'b0);
    run_frame(32'h0A000005, 32'h0A000006, 16'd11, 16'd12, 16'd40, 1'b0, 10, 0, 5, 1'b0);
    run_frame(32'h0A000005, 32'h0A000006, 16'd11, 16'd12, 16'd7, 1'b0, 2, 0, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      plen = $urandom_range(0, 60);
      nb   = (plen + DB - 1) / DB;
      r    = $urandom_range(0, 5);
      k    = nb;
      if (r == 0 && nb > 1) k = nb - 1;
      if (r == 1 && nb > 0) k = nb + 1;
      run_frame($urandom, $urandom, 16'($urandom), 16'($urandom), 16'(plen),
                1'($urandom_range(0, 3) == 0), k, 2, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
